// File: rtl/pool_ctrl.sv
// Control unit for a 2-D max-pooling stage: consumes an upstream ping-pong bank and
// sequences window reads, datapath load/compare and pooled writes. Optional frames_done
// counter is built when POOL_FRAME_CNT_EN is defined.
module pool_ctrl #(
  parameter int IFM_SIZE   = 10,
  parameter int IFM_DEPTH  = 2,
  parameter int POOL_SIZE  = 2,
  parameter int OFM_SIZE   = IFM_SIZE / POOL_SIZE,
  parameter int ADDR_IFM   = $clog2(IFM_SIZE * IFM_SIZE),
  parameter int ADDR_OFM   = $clog2(OFM_SIZE * OFM_SIZE),
  parameter int DEPTH_BITS = (IFM_DEPTH > 2) ? $clog2(IFM_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_from_previous,
  output logic                  end_to_previous,
  output logic                  ifm_sel,
  output logic                  ifm_enable_read,
  output logic [ADDR_IFM-1:0]   ifm_address_read,
  output logic [DEPTH_BITS-1:0] ifm_depth_sel,
  output logic                  pool_load,
  output logic                  pool_compare,
  output logic                  ofm_enable_write,
  output logic [ADDR_OFM-1:0]   ofm_address_write,
  output logic [DEPTH_BITS-1:0] ofm_depth_sel,
  input  logic                  end_from_next,
  output logic                  start_to_next
`ifdef POOL_FRAME_CNT_EN
  ,
  output logic [15:0]           frames_done
`endif
);

  localparam int WIN_W = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
  localparam int OUT_W = (OFM_SIZE > 1) ? $clog2(OFM_SIZE) : 1;

  localparam logic [WIN_W-1:0]      WIN_MAX   = WIN_W'(POOL_SIZE - 1);
  localparam logic [OUT_W-1:0]      OUT_MAX   = OUT_W'(OFM_SIZE - 1);
  localparam logic [DEPTH_BITS-1:0] DEPTH_MAX = DEPTH_BITS'(IFM_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t state, state_next;

  logic [WIN_W-1:0]      wc, wr;
  logic [OUT_W-1:0]      c, r;
  logic [DEPTH_BITS-1:0] d;
  logic                  drain_cnt;
  logic                  pending;

  logic wc_last, wr_last, c_last, r_last, d_last;
  logic win_first, win_last, read_last;
  logic accept, drain_done;

  assign wc_last   = (wc == WIN_MAX);
  assign wr_last   = (wr == WIN_MAX);
  assign c_last    = (c == OUT_MAX);
  assign r_last    = (r == OUT_MAX);
  assign d_last    = (d == DEPTH_MAX);
  assign win_first = (wc == '0) && (wr == '0);
  assign win_last  = wc_last && wr_last;
  assign read_last = win_last && c_last && r_last && d_last;

  assign accept     = (state == IDLE) && start_from_previous && !pending;
  assign drain_done = (state == DRAIN) && drain_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)     state_next = READ;
      READ:    if (read_last)  state_next = DRAIN;
      DRAIN:   if (drain_done) state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Handshake: bank toggle on accepted start, pending holds a finished frame until
  // downstream can take it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifm_sel   <= 1'b0;
      pending   <= 1'b0;
      drain_cnt <= 1'b0;
    end else begin
      if (accept) ifm_sel <= ~ifm_sel;
      if (drain_done)                   pending <= 1'b1;
      else if (pending && end_from_next) pending <= 1'b0;
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
    end
  end

  assign end_to_previous = (state == IDLE) && !pending;
  assign start_to_next   = pending && end_from_next;

  // Scan counters, innermost window column first; all wrap to zero on the last read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wc <= '0;
      wr <= '0;
      c  <= '0;
      r  <= '0;
      d  <= '0;
    end else if (state == READ) begin
      wc <= wc_last ? '0 : wc + WIN_W'(1);
      if (wc_last) begin
        wr <= wr_last ? '0 : wr + WIN_W'(1);
        if (wr_last) begin
          c <= c_last ? '0 : c + OUT_W'(1);
          if (c_last) begin
            r <= r_last ? '0 : r + OUT_W'(1);
            if (r_last) d <= d_last ? '0 : d + DEPTH_BITS'(1);
          end
        end
      end
    end
  end

  assign ifm_enable_read  = (state == READ);
  assign ifm_address_read = ifm_enable_read
      ? ADDR_IFM'((int'(r) * POOL_SIZE + int'(wr)) * IFM_SIZE + int'(c) * POOL_SIZE + int'(wc))
      : '0;
  assign ifm_depth_sel    = ifm_enable_read ? d : '0;

  // Stage p1: read data returns from memory; datapath loads or compares.
  logic                  vld_p1, first_p1, last_p1;
  logic [ADDR_OFM-1:0]   oaddr_p1;
  logic [DEPTH_BITS-1:0] depth_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      first_p1 <= 1'b0;
      last_p1  <= 1'b0;
      oaddr_p1 <= '0;
      depth_p1 <= '0;
    end else begin
      vld_p1   <= ifm_enable_read;
      first_p1 <= win_first;
      last_p1  <= win_last;
      oaddr_p1 <= ADDR_OFM'(int'(r) * OFM_SIZE + int'(c));
      depth_p1 <= d;
    end
  end

  assign pool_load    = vld_p1 && first_p1;
  assign pool_compare = vld_p1 && !first_p1;

  // Stage p2: window maximum is complete in the datapath register; write it out.
  logic                  vld_p2;
  logic [ADDR_OFM-1:0]   oaddr_p2;
  logic [DEPTH_BITS-1:0] depth_p2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p2   <= 1'b0;
      oaddr_p2 <= '0;
      depth_p2 <= '0;
    end else begin
      vld_p2   <= vld_p1 && last_p1;
      oaddr_p2 <= oaddr_p1;
      depth_p2 <= depth_p1;
    end
  end

  assign ofm_enable_write  = vld_p2;
  assign ofm_address_write = vld_p2 ? oaddr_p2 : '0;
  assign ofm_depth_sel     = vld_p2 ? depth_p2 : '0;

`ifdef POOL_FRAME_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              frames_done <= 16'd0;
    else if (start_to_next) frames_done <= frames_done + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pool_ctrl.sv
// Directed bench for pool_ctrl with IFM_SIZE=4, IFM_DEPTH=2, POOL_SIZE=2.
module tb_pool_ctrl;

  localparam int IFM_SIZE = 4;
  localparam int IFM_DEPTH = 2;
  localparam int POOL_SIZE = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_from_previous = 1'b0;
  logic       end_from_next = 1'b0;
  logic       end_to_previous, ifm_sel, ifm_enable_read;
  logic [3:0] ifm_address_read;
  logic [0:0] ifm_depth_sel;
  logic       pool_load, pool_compare, ofm_enable_write;
  logic [1:0] ofm_address_write;
  logic [0:0] ofm_depth_sel;
  logic       start_to_next;
`ifdef POOL_FRAME_CNT_EN
  logic [15:0] frames_done;
`endif

  pool_ctrl #(.IFM_SIZE(IFM_SIZE), .IFM_DEPTH(IFM_DEPTH), .POOL_SIZE(POOL_SIZE)) dut (
    .clk(clk), .reset(reset),
    .start_from_previous(start_from_previous), .end_to_previous(end_to_previous),
    .ifm_sel(ifm_sel), .ifm_enable_read(ifm_enable_read),
    .ifm_address_read(ifm_address_read), .ifm_depth_sel(ifm_depth_sel),
    .pool_load(pool_load), .pool_compare(pool_compare),
    .ofm_enable_write(ofm_enable_write), .ofm_address_write(ofm_address_write),
    .ofm_depth_sel(ofm_depth_sel), .end_from_next(end_from_next),
    .start_to_next(start_to_next)
`ifdef POOL_FRAME_CNT_EN
    , .frames_done(frames_done)
`endif
  );

  always #5 clk = ~clk;

  int pcnt = 0;
  int t0 = 0;
  always @(posedge clk) pcnt++;

  int n_checks = 0;
  int n_fail = 0;

  int rd_addr[$], rd_dep[$], rd_idx[$];
  int wr_addr[$], wr_dep[$], wr_idx[$];
  int stn_idx[$];
  int n_load = 0, n_cmp = 0;

  // Index k means "signal presented for sampling at edge k" (edge 0 samples the start).
  always begin
    @(negedge clk);
    #2;
    if (ifm_enable_read) begin
      rd_addr.push_back(int'(ifm_address_read));
      rd_dep.push_back(int'(ifm_depth_sel));
      rd_idx.push_back(pcnt - t0);
    end
    if (ofm_enable_write) begin
      wr_addr.push_back(int'(ofm_address_write));
      wr_dep.push_back(int'(ofm_depth_sel));
      wr_idx.push_back(pcnt - t0);
    end
    if (pool_load) n_load++;
    if (pool_compare) n_cmp++;
    if (start_to_next) stn_idx.push_back(pcnt - t0);
  end

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clear_logs();
    rd_addr.delete(); rd_dep.delete(); rd_idx.delete();
    wr_addr.delete(); wr_dep.delete(); wr_idx.delete();
    stn_idx.delete();
    n_load = 0;
    n_cmp = 0;
  endtask

  task automatic start_frame();
    @(negedge clk);
    clear_logs();
    t0 = pcnt;
    start_from_previous = 1'b1;
    @(negedge clk);
    start_from_previous = 1'b0;
  endtask

  task automatic wait_idx(input int n);
    while (pcnt - t0 < n) @(negedge clk);
  endtask

  int exp_rd[12] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13};
  int exp_wa[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
  int exp_wd[8]  = '{0, 0, 0, 0, 1, 1, 1, 1};

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_etp", int'(end_to_previous), 1);
    check("rst_rd_en", int'(ifm_enable_read), 0);
    check("rst_wr_en", int'(ofm_enable_write), 0);
    check("rst_ifm_sel", int'(ifm_sel), 0);
    check("rst_stn", int'(start_to_next), 0);
    check("rst_addr", int'(ifm_address_read), 0);
    @(negedge clk);
    reset = 1'b0;

    // Frame 1: downstream busy until edge 50; extra starts are ignored.
    start_frame();
    wait_idx(10);
    start_from_previous = 1'b1;
    #2;
    check("etp_busy", int'(end_to_previous), 0);
    wait_idx(11);
    start_from_previous = 1'b0;
    wait_idx(40);
    start_from_previous = 1'b1;
    #2;
    check("etp_pending", int'(end_to_previous), 0);
    wait_idx(41);
    start_from_previous = 1'b0;
    wait_idx(45);
    check("f1_reads", rd_addr.size(), 32);
    check("f1_rd_first", qget(rd_idx, 0), 1);
    check("f1_rd_last", qget(rd_idx, 31), 32);
    for (int i = 0; i < 12; i++)
      check($sformatf("f1_rd_addr%0d", i), qget(rd_addr, i), exp_rd[i]);
    check("f1_dep_r16", qget(rd_dep, 15), 0);
    check("f1_dep_r17", qget(rd_dep, 16), 1);
    check("f1_writes", wr_addr.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("f1_wr_addr%0d", i), qget(wr_addr, i), exp_wa[i]);
      check($sformatf("f1_wr_dep%0d", i), qget(wr_dep, i), exp_wd[i]);
    end
    check("f1_wr_first", qget(wr_idx, 0), 6);
    check("f1_wr_last", qget(wr_idx, 7), 34);
    check("f1_loads", n_load, 8);
    check("f1_cmps", n_cmp, 24);
    check("f1_ifm_sel", int'(ifm_sel), 1);
    check("f1_no_stn_yet", stn_idx.size(), 0);
    wait_idx(50);
    end_from_next = 1'b1;
    wait_idx(52);
    #2;
    check("f1_stn_count", stn_idx.size(), 1);
    check("f1_stn_edge", qget(stn_idx, 0), 50);
    check("f1_etp_after", int'(end_to_previous), 1);

    // Frame 2: downstream already ready at frame end.
    start_frame();
    wait_idx(40);
    check("f2_reads", rd_addr.size(), 32);
    check("f2_stn_count", stn_idx.size(), 1);
    check("f2_stn_edge", qget(stn_idx, 0), 35);
    check("f2_ifm_sel", int'(ifm_sel), 0);

    // Frame 3: asynchronous reset during read 10.
    start_frame();
    wait_idx(10);
    #3;
    reset = 1'b1;
    #1;
    check("ar_reads_before", rd_addr.size(), 10);
    check("ar_read10_addr", qget(rd_addr, 9), 9);
    check("ar_rd_en", int'(ifm_enable_read), 0);
    check("ar_etp", int'(end_to_previous), 1);
    check("ar_ifm_sel", int'(ifm_sel), 0);
    check("ar_addr", int'(ifm_address_read), 0);
    check("ar_load", int'(pool_load), 0);
    check("ar_cmp", int'(pool_compare), 0);
    @(negedge clk);
    reset = 1'b0;

    for (int f = 0; f < 3; f++) begin
      start_frame();
      wait_idx(40);
      check($sformatf("pr%0d_reads", f), rd_addr.size(), 32);
      check($sformatf("pr%0d_addr0", f), qget(rd_addr, 0), 0);
      check($sformatf("pr%0d_addr2", f), qget(rd_addr, 2), 4);
      check($sformatf("pr%0d_writes", f), wr_addr.size(), 8);
      check($sformatf("pr%0d_stn", f), stn_idx.size(), 1);
    end
    check("pr_ifm_sel", int'(ifm_sel), 1);
`ifdef POOL_FRAME_CNT_EN
    check("frames_done", int'(frames_done), 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
